// File: rtl/cra_pkg.sv
// Shared types and constants for the CRA next-address stage: the 11-bit
// microaddress (bit 0 = MSB) and the CRAM_DISP dispatch codes.
package cra_pkg;

    typedef logic [0:10] cra_addr_t;
    typedef logic [0:2]  cra_disp_t;

    localparam cra_disp_t DISP_JUMP = 3'd0;
    localparam cra_disp_t DISP_DRJ  = 3'd1;
    localparam cra_disp_t DISP_DRA  = 3'd2;
    localparam cra_disp_t DISP_DRB  = 3'd3;
    localparam cra_disp_t DISP_NORM = 3'd4;
    localparam cra_disp_t DISP_SKIP = 3'd5;
    localparam cra_disp_t DISP_CALL = 3'd6;
    localparam cra_disp_t DISP_RET  = 3'd7;

    localparam cra_addr_t CRADR_RESET = 11'd0;

endpackage

// File: rtl/cra_dispatch_if.sv
// Bus between the IR/microword sources and the CRA dispatch stage; the master
// drives the dispatch inputs, the slave (cra_dispatch) drives CRADR and status.
interface cra_dispatch_if;

    logic         eboxAdvance;
    logic [0:10]  CRAM_J;
    logic [0:2]   CRAM_DISP;
    logic [2:0]   DRAM_A;
    logic [2:0]   DRAM_B;
    logic [10:0]  DRAM_J;
    logic [8:10]  norm;
    logic         testSatisfied;
    logic [0:2]   diagHistSel;
    logic [0:10]  CRADR;
    logic [0:6]   stackDepth;
    logic         stackOverflow;
    logic         stackUnderflow;
    logic [0:10]  diagHistAddr;

    modport master (
        output eboxAdvance, CRAM_J, CRAM_DISP, DRAM_A, DRAM_B, DRAM_J, norm,
               testSatisfied, diagHistSel,
        input  CRADR, stackDepth, stackOverflow, stackUnderflow, diagHistAddr
    );

    modport slave (
        input  eboxAdvance, CRAM_J, CRAM_DISP, DRAM_A, DRAM_B, DRAM_J, norm,
               testSatisfied, diagHistSel,
        output CRADR, stackDepth, stackOverflow, stackUnderflow, diagHistAddr
    );

endinterface

// File: rtl/cra_stack.sv
// Microcode CALL/RET return-address LIFO with sticky overflow/underflow flags.
// A push while full or a pop while empty only sets the fault flag.
module cra_stack
    import cra_pkg::*;
#(
    parameter int STACK_DEPTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  cra_addr_t push_data,
    output cra_addr_t pop_data,
    output logic [6:0] depth,
    output logic      overflow,
    output logic      underflow
);

    localparam int PW = $clog2(STACK_DEPTH);

    cra_addr_t       mem [STACK_DEPTH];
    logic [6:0]      count;
    logic            full;
    logic            empty;
    logic [PW-1:0]   top_idx;

    assign full     = (count == 7'(STACK_DEPTH));
    assign empty    = (count == 7'd0);
    assign top_idx  = count[PW-1:0] - PW'(1);
    assign pop_data = empty ? CRADR_RESET : mem[top_idx];
    assign depth    = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 7'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (push) begin
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + 7'd1;
            end
        end else if (pop) begin
            if (empty) begin
                underflow <= 1'b1;
            end else begin
                count <= count - 7'd1;
            end
        end
    end

    // Entry storage needs no reset: only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[count[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cra_dispatch.sv
// CRA next-microaddress stage: dispatch mux, CRADR register, CALL/RET stack and,
// when CRA_HISTORY_EN is defined, a HIST_DEPTH-entry CRADR history for diagnostics.
module cra_dispatch
    import cra_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int HIST_DEPTH  = 8
) (
    input  logic           eboxClk,
    input  logic           eboxReset,
    cra_dispatch_if.slave  bus
);

    cra_addr_t  cradr;
    cra_addr_t  next_addr;
    cra_addr_t  ret_addr;
    logic       push;
    logic       pop;
    logic [6:0] depth;
    logic       overflow;
    logic       underflow;

    always_comb begin
        next_addr = bus.CRAM_J;
        push      = 1'b0;
        pop       = 1'b0;
        case (bus.CRAM_DISP)
            DISP_JUMP: next_addr = bus.CRAM_J;
            DISP_DRJ:  next_addr = bus.DRAM_J;
            DISP_DRA:  next_addr = {bus.CRAM_J[0:7], bus.CRAM_J[8:10] | bus.DRAM_A};
            DISP_DRB:  next_addr = {bus.CRAM_J[0:7], bus.CRAM_J[8:10] | bus.DRAM_B};
            DISP_NORM: next_addr = {bus.CRAM_J[0:7], bus.CRAM_J[8:10] | bus.norm};
            DISP_SKIP: next_addr = {bus.CRAM_J[0:9], bus.CRAM_J[10] | bus.testSatisfied};
            DISP_CALL: push      = bus.eboxAdvance;
            DISP_RET: begin
                pop       = bus.eboxAdvance;
                next_addr = ret_addr;
            end
            default:   next_addr = bus.CRAM_J;
        endcase
    end

    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            cradr <= CRADR_RESET;
        end else if (bus.eboxAdvance) begin
            cradr <= next_addr;
        end
    end

    // The return address wraps naturally in 11 bits (0o3777 + 1 = 0).
    cra_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk        (eboxClk),
        .reset      (eboxReset),
        .push       (push),
        .pop        (pop),
        .push_data  (cradr + 11'd1),
        .pop_data   (ret_addr),
        .depth      (depth),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    assign bus.CRADR          = cradr;
    assign bus.stackDepth     = depth;
    assign bus.stackOverflow  = overflow;
    assign bus.stackUnderflow = underflow;

`ifdef CRA_HISTORY_EN
    cra_addr_t hist [HIST_DEPTH];
    cra_addr_t hist_addr;

    // Entry 0 is always the newest committed CRADR.
    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= CRADR_RESET;
            end
        end else if (bus.eboxAdvance) begin
            hist[0] <= next_addr;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    always_comb begin
        hist_addr = CRADR_RESET;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (int'(bus.diagHistSel) == i) begin
                hist_addr = hist[i];
            end
        end
    end

    assign bus.diagHistAddr = hist_addr;
`else
    assign bus.diagHistAddr = CRADR_RESET;
`endif

endmodule

// File: tb/tb_cra_dispatch.sv
// Randomised scoreboard bench for cra_dispatch against a queue-based reference
// model; expected history follows CRA_HISTORY_EN when the macro is defined.
module tb_cra_dispatch;

    localparam int STACK_DEPTH = 16;
    localparam int HIST_DEPTH  = 8;

    typedef struct {
        int cradr;
        int depth;
        int ovf;
        int unf;
        int hist;
    } exp_t;

    logic clk;
    logic rst;
    cra_dispatch_if bus();

    cra_dispatch #(
        .STACK_DEPTH (STACK_DEPTH),
        .HIST_DEPTH  (HIST_DEPTH)
    ) dut (
        .eboxClk   (clk),
        .eboxReset (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    // Reference model state: return addresses and recent CRADRs (newest first).
    int m_cradr;
    int m_stack[$];
    int m_ovf;
    int m_unf;
    int m_hist[$];

    function automatic void modelReset();
        m_cradr = 0;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
        m_hist.delete();
        for (int i = 0; i < HIST_DEPTH; i++) m_hist.push_back(0);
    endfunction

    function automatic void modelStep(bit r, bit adv, int disp, int j, int a, int b,
                                      int dj, int nrm, int ts);
        int nxt;
        if (r) begin
            modelReset();
            return;
        end
        if (!adv) return;
        nxt = j;
        case (disp)
            1: nxt = dj;
            2: nxt = j | a;
            3: nxt = j | b;
            4: nxt = j | nrm;
            5: nxt = j | ts;
            6: begin
                if (m_stack.size() == STACK_DEPTH) m_ovf = 1;
                else m_stack.push_back((m_cradr + 1) % 2048);
            end
            7: begin
                if (m_stack.size() == 0) begin
                    m_unf = 1;
                    nxt = 0;
                end else begin
                    nxt = m_stack.pop_back();
                end
            end
            default: nxt = j;
        endcase
        m_cradr = nxt;
        m_hist.push_front(nxt);
        void'(m_hist.pop_back());
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input int expv);
        checks++;
        if (act !== 32'(expv)) begin
            errors++;
            $display("[TB] FAIL %s actual=%0o expected=%0o at %0t", name, act, expv, $time);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        e = expQ.pop_front();
        checkField("cradr",     {21'd0, bus.CRADR},        e.cradr);
        checkField("depth",     {25'd0, bus.stackDepth},   e.depth);
        checkField("overflow",  {31'd0, bus.stackOverflow},  e.ovf);
        checkField("underflow", {31'd0, bus.stackUnderflow}, e.unf);
        checkField("hist",      {21'd0, bus.diagHistAddr}, e.hist);
    endtask

    // Drive one cycle, advance the model over the same edge, queue the expectation.
    task automatic applyStimulus(input bit r, input bit adv, input int disp, input int j,
                                 input int a = 0, input int b = 0, input int dj = 0,
                                 input int nrm = 0, input int ts = 0, input int sel = 0);
        exp_t e;
        rst               = r;
        bus.eboxAdvance   = adv;
        bus.CRAM_DISP     = 3'(disp);
        bus.CRAM_J        = 11'(j);
        bus.DRAM_A        = 3'(a);
        bus.DRAM_B        = 3'(b);
        bus.DRAM_J        = 11'(dj);
        bus.norm          = 3'(nrm);
        bus.testSatisfied = 1'(ts);
        bus.diagHistSel   = 3'(sel);
        @(posedge clk);
        #1;
        modelStep(r, adv, disp, j, a, b, dj, nrm, ts);
        e.cradr = m_cradr;
        e.depth = m_stack.size();
        e.ovf   = m_ovf;
        e.unf   = m_unf;
`ifdef CRA_HISTORY_EN
        e.hist  = (sel < HIST_DEPTH) ? m_hist[sel] : 0;
`else
        e.hist  = 0;
`endif
        expQ.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) checkOutput();
        end
    end

    initial begin
        int wait_cycles;
        modelReset();
        rst = 1'b1;
        bus.eboxAdvance = 1'b0;
        bus.CRAM_DISP = '0;
        bus.CRAM_J = '0;
        bus.DRAM_A = '0;
        bus.DRAM_B = '0;
        bus.DRAM_J = '0;
        bus.norm = '0;
        bus.testSatisfied = 1'b0;
        bus.diagHistSel = '0;

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 'o1234);
        applyStimulus(0, 1, 0, 'o1234);

        applyStimulus(0, 1, 0, 'o0100);
        applyStimulus(0, 1, 6, 'o2000);
        applyStimulus(0, 1, 7, 'o0000);

        applyStimulus(0, 1, 5, 'o0500, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 5, 'o0500, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 2, 'o0770, 3);
        applyStimulus(0, 1, 3, 'o0770, 0, 5);
        applyStimulus(0, 1, 4, 'o1000, 0, 0, 0, 6);
        applyStimulus(0, 1, 1, 'o0001, 0, 0, 'o3456);

        applyStimulus(0, 1, 0, 'o3777);
        for (int i = 0; i <= STACK_DEPTH; i++) applyStimulus(0, 1, 6, 'o100 + i);
        for (int i = 0; i <= STACK_DEPTH; i++) applyStimulus(0, 1, 7, 0);

        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 'o0400);
        applyStimulus(0, 1, 6, 'o0600);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 6, 'o1700);
        applyStimulus(1, 0, 6, 'o1700);

        applyStimulus(0, 1, 0, 'o10);
        applyStimulus(0, 1, 0, 'o20);
        applyStimulus(0, 1, 0, 'o30, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 'o40, 0, 0, 0, 0, 0, 2);

        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(7) != 0),
                          $urandom_range(7), $urandom_range(2047),
                          $urandom_range(7), $urandom_range(7), $urandom_range(2047),
                          $urandom_range(7), $urandom_range(1), $urandom_range(7));
        end

        wait_cycles = 0;
        while (expQ.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain actual=%0d expected=0 entries left", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
